// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch stage.
package instr_fetch_stage_pkg;

   // Fetch sequencer states.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   // Every LEGv8 instruction is one 32-bit word.
   localparam int INSTR_BYTES = 4;

   // RedirectSel encodings.
   localparam logic BR_PCREL = 1'b0;
   localparam logic BR_REG   = 1'b1;

endpackage : instr_fetch_stage_pkg

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory handshake plus the decode-facing instruction bus.
interface instr_fetch_stage_if #(
   parameter int PC_W = 64
);

   logic            ImemReq;
   logic [PC_W-1:0] ImemAddr;
   logic            ImemGnt;
   logic            ImemRespValid;
   logic [31:0]     ImemRespData;
   logic            InstrValid;
   logic [31:0]     Instr;
   logic [PC_W-1:0] InstrPC;
   logic            DecodeReady;

   // Fetch stage side.
   modport master (
      output ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
      input  ImemGnt, ImemRespValid, ImemRespData, DecodeReady
   );

   // Memory / decode side.
   modport slave (
      input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
      output ImemGnt, ImemRespValid, ImemRespData, DecodeReady
   );

endinterface : instr_fetch_stage_if

// File: rtl/instr_fetch_stage_branch_target_calc.sv
// Redirect target calculation: PC-relative (BrPC + BusImm*4) or register
// target with the low two bits forced to zero and flagged if they were set.
module branch_target_calc
   import instr_fetch_stage_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic            redirect_sel,
   input  logic [PC_W-1:0] br_pc,
   input  logic [PC_W-1:0] bus_imm,
   input  logic [PC_W-1:0] br_reg,
   output logic [PC_W-1:0] target,
   output logic            misaligned
);

   // Select the target; additions wrap silently modulo 2^PC_W.
   always_comb begin
      target     = br_pc;
      misaligned = 1'b0;
      case (redirect_sel)
         BR_PCREL: begin
            target     = br_pc + {bus_imm[PC_W-3:0], 2'b00};
            misaligned = 1'b0;
         end
         BR_REG: begin
            target = {br_reg[PC_W-1:2], 2'b00};
            if (br_reg[1:0] != 2'b00) begin
               misaligned = 1'b1;
            end else begin
               misaligned = 1'b0;
            end
         end
         default: begin
            target     = br_pc;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule : branch_target_calc

// File: rtl/instr_fetch_stage.sv
// LEGv8 instruction fetch stage: holds the PC, runs a single-outstanding
// request/grant/response fetch, presents the word to decode and handles
// branch/register redirects including squash of an in-flight fetch.
module instr_fetch_stage
   import instr_fetch_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          PC_W     = 64
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   instr_fetch_stage_if.master    bus,
   input  logic                   Redirect,
   input  logic                   RedirectSel,
   input  logic [PC_W-1:0]        BrPC,
   input  logic [PC_W-1:0]        BusImm,
   input  logic [PC_W-1:0]        BrReg,
   output logic                   AlignFault
);

   fetch_state_e    state_r,       state_next_s;
   logic [PC_W-1:0] pc_r,          pc_next_s;
   logic [PC_W-1:0] req_pc_r,      req_pc_next_s;
   logic [31:0]     instr_r,       instr_next_s;
   logic [PC_W-1:0] instr_pc_r,    instr_pc_next_s;
   logic            instr_valid_r, instr_valid_next_s;
   logic            squash_r,      squash_next_s;
   logic            align_fault_r, align_fault_next_s;
   logic            imem_req_s;
   logic [PC_W-1:0] target_s;
   logic            target_misaligned_s;

   branch_target_calc #(.PC_W(PC_W)) u_branch_target_calc (
      .redirect_sel (RedirectSel),
      .br_pc        (BrPC),
      .bus_imm      (BusImm),
      .br_reg       (BrReg),
      .target       (target_s),
      .misaligned   (target_misaligned_s)
   );

   // Next-state logic; a redirect overrides every normal transition.
   always_comb begin
      state_next_s       = state_r;
      pc_next_s          = pc_r;
      req_pc_next_s      = req_pc_r;
      instr_next_s       = instr_r;
      instr_pc_next_s    = instr_pc_r;
      instr_valid_next_s = instr_valid_r;
      squash_next_s      = squash_r;
      align_fault_next_s = 1'b0;
      imem_req_s         = 1'b0;

      if (Redirect) begin
         align_fault_next_s = target_misaligned_s;
      end else begin
         align_fault_next_s = 1'b0;
      end

      case (state_r)
         FETCH: begin
            if (Redirect) begin
               // Request gated off so no grant can race the new PC.
               imem_req_s   = 1'b0;
               pc_next_s    = target_s;
               state_next_s = FETCH;
            end else begin
               imem_req_s = 1'b1;
               if (bus.ImemGnt) begin
                  req_pc_next_s = pc_r;
                  state_next_s  = WAIT;
               end else begin
                  state_next_s = FETCH;
               end
            end
         end
         WAIT: begin
            if (bus.ImemRespValid) begin
               if (Redirect) begin
                  pc_next_s     = target_s;
                  squash_next_s = 1'b0;
                  state_next_s  = FETCH;
               end else if (squash_r) begin
                  squash_next_s = 1'b0;
                  state_next_s  = FETCH;
               end else begin
                  instr_next_s       = bus.ImemRespData;
                  instr_pc_next_s    = req_pc_r;
                  instr_valid_next_s = 1'b1;
                  pc_next_s          = req_pc_r + PC_W'(INSTR_BYTES);
                  state_next_s       = HOLD;
               end
            end else begin
               if (Redirect) begin
                  // Response still owed; remember to drop it.
                  pc_next_s     = target_s;
                  squash_next_s = 1'b1;
               end else begin
                  squash_next_s = squash_r;
               end
               state_next_s = WAIT;
            end
         end
         HOLD: begin
            if (Redirect) begin
               pc_next_s          = target_s;
               instr_valid_next_s = 1'b0;
               state_next_s       = FETCH;
            end else if (bus.DecodeReady) begin
               instr_valid_next_s = 1'b0;
               state_next_s       = FETCH;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            instr_valid_next_s = 1'b0;
            squash_next_s      = 1'b0;
            state_next_s       = FETCH;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_r       <= FETCH;
         pc_r          <= RESET_PC[PC_W-1:0];
         req_pc_r      <= {PC_W{1'b0}};
         instr_r       <= 32'h0;
         instr_pc_r    <= {PC_W{1'b0}};
         instr_valid_r <= 1'b0;
         squash_r      <= 1'b0;
         align_fault_r <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         pc_r          <= pc_next_s;
         req_pc_r      <= req_pc_next_s;
         instr_r       <= instr_next_s;
         instr_pc_r    <= instr_pc_next_s;
         instr_valid_r <= instr_valid_next_s;
         squash_r      <= squash_next_s;
         align_fault_r <= align_fault_next_s;
      end
   end

   assign bus.ImemReq    = imem_req_s;
   assign bus.ImemAddr   = pc_r;
   assign bus.InstrValid = instr_valid_r;
   assign bus.Instr      = instr_r;
   assign bus.InstrPC    = instr_pc_r;
   assign AlignFault     = align_fault_r;

endmodule : instr_fetch_stage

// File: tb/tb_instr_fetch_stage.sv
// Directed self-checking bench for instr_fetch_stage.
module tb_instr_fetch_stage;

   localparam int PC_W = 64;

   logic            Clk;
   logic            Reset_n;
   logic            Redirect;
   logic            RedirectSel;
   logic [PC_W-1:0] BrPC;
   logic [PC_W-1:0] BusImm;
   logic [PC_W-1:0] BrReg;
   logic            AlignFault;

   int vectors;
   int miscompares;

   instr_fetch_stage_if #(.PC_W(PC_W)) bus ();

   instr_fetch_stage #(.RESET_PC(64'h0), .PC_W(PC_W)) dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .bus         (bus),
      .Redirect    (Redirect),
      .RedirectSel (RedirectSel),
      .BrPC        (BrPC),
      .BusImm      (BusImm),
      .BrReg       (BrReg),
      .AlignFault  (AlignFault)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      Reset_n     = 1'b1;
      Redirect    = 1'b0;
      RedirectSel = 1'b0;
      BrPC        = 64'h0;
      BusImm      = 64'h0;
      BrReg       = 64'h0;
      bus.ImemGnt       = 1'b0;
      bus.ImemRespValid = 1'b0;
      bus.ImemRespData  = 32'h0;
      bus.DecodeReady   = 1'b0;
      #2 Reset_n = 1'b0;
      tick();
      tick();
      chk("rst_valid", {63'h0, bus.InstrValid}, 64'h0);
      chk("rst_instr", {32'h0, bus.Instr}, 64'h0);
      chk("rst_instrpc", bus.InstrPC, 64'h0);
      chk("rst_addr", bus.ImemAddr, 64'h0);
      chk("rst_alignfault", {63'h0, AlignFault}, 64'h0);

      // Zero-wait memory, decode always ready.
      bus.ImemGnt       = 1'b1;
      bus.ImemRespValid = 1'b1;
      bus.ImemRespData  = 32'hD503201F;
      bus.DecodeReady   = 1'b1;
      Reset_n           = 1'b1;
      #1;
      chk("first_req", {63'h0, bus.ImemReq}, 64'h1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("wait_valid", {63'h0, bus.InstrValid}, 64'h0);
         chk("wait_req", {63'h0, bus.ImemReq}, 64'h0);
         tick();
         chk("hold_valid", {63'h0, bus.InstrValid}, 64'h1);
         chk("hold_instr", {32'h0, bus.Instr}, 64'h00000000D503201F);
         chk("hold_instrpc", bus.InstrPC, 64'(4 * k));
         tick();
         chk("next_valid", {63'h0, bus.InstrValid}, 64'h0);
         chk("next_req", {63'h0, bus.ImemReq}, 64'h1);
         chk("next_addr", bus.ImemAddr, 64'(4 * k + 4));
      end

      // Decode stalls for 5 cycles in HOLD.
      bus.DecodeReady = 1'b0;
      tick();
      tick();
      chk("stall_valid", {63'h0, bus.InstrValid}, 64'h1);
      chk("stall_instrpc", bus.InstrPC, 64'hC);
      bus.ImemRespData = 32'hDEADBEEF;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_hold_valid", {63'h0, bus.InstrValid}, 64'h1);
         chk("stall_hold_instrpc", bus.InstrPC, 64'hC);
         chk("stall_hold_instr", {32'h0, bus.Instr}, 64'h00000000D503201F);
         chk("stall_hold_req", {63'h0, bus.ImemReq}, 64'h0);
      end
      bus.DecodeReady = 1'b1;
      tick();
      chk("stall_release_valid", {63'h0, bus.InstrValid}, 64'h0);
      chk("stall_release_req", {63'h0, bus.ImemReq}, 64'h1);
      chk("stall_release_addr", bus.ImemAddr, 64'h10);

      // PC-relative redirect in HOLD with negative offset: 0x100 - 8.
      tick();
      tick();
      chk("pre_redir_valid", {63'h0, bus.InstrValid}, 64'h1);
      chk("pre_redir_instr", {32'h0, bus.Instr}, 64'h00000000DEADBEEF);
      chk("pre_redir_instrpc", bus.InstrPC, 64'h10);
      Redirect    = 1'b1;
      RedirectSel = 1'b0;
      BrPC        = 64'h100;
      BusImm      = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      Redirect          = 1'b0;
      bus.ImemRespValid = 1'b0;
      #1;
      chk("redir_hold_valid", {63'h0, bus.InstrValid}, 64'h0);
      chk("redir_hold_addr", bus.ImemAddr, 64'hF8);
      chk("redir_hold_req", {63'h0, bus.ImemReq}, 64'h1);
      chk("redir_hold_af", {63'h0, AlignFault}, 64'h0);

      // Register redirect in WAIT a cycle ahead of the response.
      tick();
      Redirect    = 1'b1;
      RedirectSel = 1'b1;
      BrReg       = 64'h2000;
      tick();
      Redirect = 1'b0;
      #1;
      chk("squash_af", {63'h0, AlignFault}, 64'h0);
      chk("squash_req", {63'h0, bus.ImemReq}, 64'h0);
      chk("squash_valid", {63'h0, bus.InstrValid}, 64'h0);
      bus.ImemRespValid = 1'b1;
      bus.ImemRespData  = 32'h11111111;
      tick();
      bus.ImemRespValid = 1'b0;
      #1;
      chk("squash_drop_valid", {63'h0, bus.InstrValid}, 64'h0);
      chk("squash_drop_instr", {32'h0, bus.Instr}, 64'h00000000DEADBEEF);
      chk("squash_drop_req", {63'h0, bus.ImemReq}, 64'h1);
      chk("squash_drop_addr", bus.ImemAddr, 64'h2000);

      // Misaligned register target in FETCH.
      Redirect    = 1'b1;
      RedirectSel = 1'b1;
      BrReg       = 64'h2003;
      #1;
      chk("redir_gate_req", {63'h0, bus.ImemReq}, 64'h0);
      tick();
      Redirect = 1'b0;
      #1;
      chk("misalign_af", {63'h0, AlignFault}, 64'h1);
      chk("misalign_addr", bus.ImemAddr, 64'h2000);
      chk("misalign_req", {63'h0, bus.ImemReq}, 64'h1);
      tick();
      chk("misalign_af_clear", {63'h0, AlignFault}, 64'h0);
      chk("misalign_wait_req", {63'h0, bus.ImemReq}, 64'h0);

      // Reset taken mid-WAIT, stray response afterwards.
      Reset_n     = 1'b0;
      bus.ImemGnt = 1'b0;
      #1;
      chk("midrst_addr", bus.ImemAddr, 64'h0);
      chk("midrst_valid", {63'h0, bus.InstrValid}, 64'h0);
      Reset_n           = 1'b1;
      bus.ImemRespValid = 1'b1;
      bus.ImemRespData  = 32'h22222222;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("stray_valid", {63'h0, bus.InstrValid}, 64'h0);
         chk("stray_addr", bus.ImemAddr, 64'h0);
         chk("stray_req", {63'h0, bus.ImemReq}, 64'h1);
      end
      bus.ImemRespValid = 1'b0;

      // Forward PC-relative redirect: 0x40 + 3*4.
      Redirect    = 1'b1;
      RedirectSel = 1'b0;
      BrPC        = 64'h40;
      BusImm      = 64'h3;
      tick();
      Redirect = 1'b0;
      #1;
      chk("pcrel_fwd_addr", bus.ImemAddr, 64'h4C);

      // PC wrap past all-ones.
      Redirect    = 1'b1;
      RedirectSel = 1'b1;
      BrReg       = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      Redirect = 1'b0;
      #1;
      chk("wrap_addr", bus.ImemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      bus.ImemGnt = 1'b1;
      tick();
      bus.ImemGnt       = 1'b0;
      bus.ImemRespValid = 1'b1;
      bus.ImemRespData  = 32'h8B020020;
      tick();
      bus.ImemRespValid = 1'b0;
      #1;
      chk("wrap_valid", {63'h0, bus.InstrValid}, 64'h1);
      chk("wrap_instrpc", bus.InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_instr", {32'h0, bus.Instr}, 64'h000000008B020020);
      tick();
      chk("wrap_next_addr", bus.ImemAddr, 64'h0);
      chk("wrap_next_valid", {63'h0, bus.InstrValid}, 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_instr_fetch_stage

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
Front end of the LEGv8 datapath. Holds the PC, fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake, and presents it to decode, where Instr[25:0] feeds the sign extender's Imm26 input. The stage also takes the sign extender's BusImm back in, forms branch targets (PC + BusImm<<2) or register targets, and squashes any fetch that is in flight when a redirect arrives.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.
PC_W, 64, PC and address width.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Reset_n  input  1  asynchronous active-low reset.
ImemReq  output  1  fetch request valid.
ImemAddr  output  PC_W  fetch address; equals PC.
ImemGnt  input  1  memory accepts the request in this cycle.
ImemRespValid  input  1  instruction data valid.
ImemRespData  input  32  fetched instruction word.
InstrValid  output  1  Instr and InstrPC hold a valid instruction for decode.
Instr  output  32  instruction word; decode slices Imm26 = Instr[25:0].
InstrPC  output  PC_W  address of Instr.
DecodeReady  input  1  decode consumes Instr this cycle.
Redirect  input  1  redirect fetch this cycle; a one-cycle pulse.
RedirectSel  input  1  0 selects PC-relative target, 1 selects register target.
BrPC  input  PC_W  PC of the redirecting branch.
BusImm  input  PC_W  sign-extended offset from the sign extender, in words.
BrReg  input  PC_W  register target used by BR.
AlignFault  output  1  one-cycle pulse: the register target was misaligned.

Behaviour:
- Reset (asynchronous, any state):
  - PC=RESET_PC; state=FETCH.
  - InstrValid=0, Instr=0, InstrPC=0, Squash=0, AlignFault=0.
  - Every other output is derived from this state.
- FETCH:
  - ImemReq=1 and ImemAddr=PC, except ImemReq=0 in any cycle where Redirect=1 (combinational gate).
  - ImemGnt=1 with ImemReq=1: ReqPC<=PC, go to WAIT.
- WAIT:
  - ImemReq=0.
  - ImemRespValid=1 with Squash=0: Instr<=ImemRespData, InstrPC<=ReqPC, InstrValid<=1, PC<=ReqPC+4, go to HOLD.
  - ImemRespValid=1 with Squash=1: discard the data, Squash<=0, go to FETCH.
- HOLD:
  - ImemReq=0; Instr and InstrPC stay stable.
  - DecodeReady=1: InstrValid<=0, go to FETCH.
- Handshake rules:
  - Only one request is ever outstanding.
  - ImemRespValid is ignored outside WAIT. This covers stray responses after a reset taken during WAIT.
  - DecodeReady is ignored while InstrValid=0.
- Redirect target:
  - RedirectSel=0: T = BrPC + (BusImm<<2).
  - RedirectSel=1: T = {BrReg[PC_W-1:2], 2'b00}. AlignFault<=1 for one cycle if BrReg[1:0]!=0.
  - All addition is modulo 2^PC_W; wrap past all-ones is silent.
- Redirect handling, evaluated each edge and overriding the normal transitions:
  - FETCH: PC<=T, stay in FETCH. A grant in the same cycle is impossible because ImemReq=0.
  - WAIT without a response this cycle: PC<=T, Squash<=1.
  - WAIT with a response this cycle: PC<=T, data dropped, go to FETCH.
  - HOLD: PC<=T, InstrValid<=0, go to FETCH. DecodeReady is irrelevant.
- Latency: grant to InstrValid is one cycle after the response edge. The minimum issue interval is 3 cycles (FETCH→WAIT→HOLD→FETCH) with a zero-wait memory.
- Redirect and reset in the same cycle: reset wins.

Decomposition:
- Shared package holds:
  - state enum FETCH=2'd0, WAIT=2'd1, HOLD=2'd2.
  - constant INSTR_BYTES=4.
  - RedirectSel encodings BR_PCREL=1'b0, BR_REG=1'b1.
- One sub-module, branch_target_calc: purely combinational. Computes T and the misalignment flag from RedirectSel, BrPC, BusImm and BrReg.

Test Plan:
- Reset release with RESET_PC=0, zero-wait memory returning 32'hD503201F, DecodeReady=1 → InstrPC sequence 0x0, 0x4, 0x8, one instruction every 3 cycles, InstrValid pulses 1 cycle each.
- DecodeReady held 0 for 5 cycles in HOLD → Instr and InstrPC stable, ImemReq=0 throughout; fetch of PC+4 starts the cycle after DecodeReady=1.
- Redirect in HOLD with RedirectSel=0, BrPC=0x100, BusImm=64'hFFFF_FFFF_FFFF_FFFE → InstrValid drops next cycle, next ImemAddr=0xF8.
- Redirect in WAIT one cycle before the response, RedirectSel=1, BrReg=0x2000 → stale response discarded (InstrValid stays 0), next ImemAddr=0x2000, AlignFault=0.
- RedirectSel=1, BrReg=0x2003 → AlignFault pulses once, next ImemAddr=0x2000.
- Reset_n asserted mid-WAIT, memory responds after release → response ignored, ImemAddr=RESET_PC, InstrValid=0. Also: PC=64'hFFFF_FFFF_FFFF_FFFC fetch → next PC wraps to 0x0.
